// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback bundle between the pipeline and hazard_scoreboard.
//   master : pipeline side, drives decode/control/writeback, reads stall/fwd
//   slave  : scoreboard side
// Signals:
//   dec_valid/rs1/rs2/use_rs1/use_rs2/we/rd/lat : instruction in decode
//   mem_stall : pipeline freeze, flush : squash in-flight producers
//   wb_valid/wb_rd : register-file write
//   stall, fwd_rs1, fwd_rs2, stall_cycles : scoreboard outputs
interface hazard_scoreboard_if #(
  parameter int NUM_REGS    = 32,
  parameter int MAX_LAT     = 8,
  parameter int STALL_CNT_W = 32
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int LW = $clog2(MAX_LAT + 1);

  logic                   dec_valid;
  logic [RW-1:0]          dec_rs1;
  logic [RW-1:0]          dec_rs2;
  logic                   dec_use_rs1;
  logic                   dec_use_rs2;
  logic                   dec_we;
  logic [RW-1:0]          dec_rd;
  logic [LW-1:0]          dec_lat;
  logic                   mem_stall;
  logic                   flush;
  logic                   wb_valid;
  logic [RW-1:0]          wb_rd;
  logic                   stall;
  logic                   fwd_rs1;
  logic                   fwd_rs2;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           dec_we, dec_rd, dec_lat, mem_stall, flush, wb_valid, wb_rd,
    input  stall, fwd_rs1, fwd_rs2, stall_cycles
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           dec_we, dec_rd, dec_lat, mem_stall, flush, wb_valid, wb_rd,
    output stall, fwd_rs1, fwd_rs2, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Latency-aware register scoreboard sitting between decode and execute.
// Tracks, per architectural register, whether a write is outstanding and how
// many cycles remain until the result reaches the bypass network. Produces a
// decode stall for RAW/WAW hazards (or pipeline freeze), bypass selects for
// sources whose producer is already forwardable, and a saturating count of
// stalled cycles.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   sb    : hazard_scoreboard_if.slave (decode, control, writeback, results)

// One tracked register: busy flag plus countdown to forwardability.
module hazard_sb_entry #(
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          mem_stall,
  input  logic          set,
  input  logic [LW-1:0] set_lat,
  input  logic          clr,
  output logic          busy,
  output logic [LW-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (set) begin
      // a new producer replaces whatever was tracked, even if the old one
      // writes back in this same cycle
      busy <= 1'b1;
      cnt  <= set_lat;
    end else begin
      if (clr) busy <= 1'b0;
      if (!mem_stall && busy && cnt != '0) cnt <= cnt - LW'(1);
    end
  end
endmodule

module hazard_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int MAX_LAT     = 8,
  parameter int STALL_CNT_W = 32
) (
  input logic               clk,
  input logic               reset,
  hazard_scoreboard_if.slave sb
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int LW = $clog2(MAX_LAT + 1);

  logic [NUM_REGS-1:0]         busy;
  logic [NUM_REGS-1:0][LW-1:0] cnt;
  logic                        raw1, raw2, waw;
  logic                        stall_i, issue;

  // register 0 is hard-wired zero: never tracked, so never busy
  genvar r;
  generate
    for (r = 0; r < NUM_REGS; r++) begin : g_reg
      if (r == 0) begin : g_zero
        assign busy[r] = 1'b0;
        assign cnt[r]  = '0;
      end else begin : g_ent
        hazard_sb_entry #(.LW(LW)) u_ent (
          .clk       (clk),
          .reset     (reset),
          .flush     (sb.flush),
          .mem_stall (sb.mem_stall),
          .set       (issue && sb.dec_we && (sb.dec_rd == RW'(r))),
          .set_lat   (sb.dec_lat),
          .clr       (sb.wb_valid && (sb.wb_rd == RW'(r))),
          .busy      (busy[r]),
          .cnt       (cnt[r])
        );
      end
    end
  endgenerate

  // RAW only while the producer is still counting; once cnt hits 0 the value
  // is on the bypass network and the consumer forwards instead.
  assign raw1 = sb.dec_use_rs1 && (sb.dec_rs1 != '0) && busy[sb.dec_rs1] && (cnt[sb.dec_rs1] != '0);
  assign raw2 = sb.dec_use_rs2 && (sb.dec_rs2 != '0) && busy[sb.dec_rs2] && (cnt[sb.dec_rs2] != '0);
  // a newer writer may not finish before the older one still in flight
  assign waw  = sb.dec_we && (sb.dec_rd != '0) && busy[sb.dec_rd] && (cnt[sb.dec_rd] > sb.dec_lat);

  assign stall_i = !reset && ((sb.dec_valid && (raw1 || raw2 || waw)) || sb.mem_stall);
  assign issue   = sb.dec_valid && !stall_i && !sb.flush;

  assign sb.stall   = stall_i;
  assign sb.fwd_rs1 = !reset && sb.dec_use_rs1 && (sb.dec_rs1 != '0) && busy[sb.dec_rs1] && (cnt[sb.dec_rs1] == '0);
  assign sb.fwd_rs2 = !reset && sb.dec_use_rs2 && (sb.dec_rs2 != '0) && busy[sb.dec_rs2] && (cnt[sb.dec_rs2] == '0);

  logic [STALL_CNT_W-1:0] stall_cycles;

  always_ff @(posedge clk) begin
    if (reset)                                   stall_cycles <= '0;
    else if (stall_i && (stall_cycles != '1))    stall_cycles <= stall_cycles + STALL_CNT_W'(1);
  end

  assign sb.stall_cycles = stall_cycles;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. The driver applies one decode cycle at
// a time and queues the hand-computed expected stall/fwd/stall_cycles; a
// separate monitor pops one expectation per cycle on the falling edge.
module tb_hazard_scoreboard;
  localparam int NUM_REGS = 32;
  localparam int MAX_LAT  = 8;
  localparam int SCW      = 32;
  localparam int RW       = 5;
  localparam int LW       = 4;

  logic clk = 1'b0;
  logic reset;

  hazard_scoreboard_if #(.NUM_REGS(NUM_REGS), .MAX_LAT(MAX_LAT), .STALL_CNT_W(SCW)) sb ();

  hazard_scoreboard #(.NUM_REGS(NUM_REGS), .MAX_LAT(MAX_LAT), .STALL_CNT_W(SCW)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  st;
    logic  f1;
    logic  f2;
    int    sc;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   errors = 0;
  int   checks = 0;

  // illegal latency must never be presented
  always @(posedge clk)
    if (!reset && sb.dec_valid && sb.dec_we && (int'(sb.dec_lat) > MAX_LAT))
      $error("illegal dec_lat %0d", sb.dec_lat);

  // monitor: one expectation per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m = q.pop_front();
      checks++;
      if (sb.stall !== m.st || sb.fwd_rs1 !== m.f1 || sb.fwd_rs2 !== m.f2 ||
          sb.stall_cycles !== SCW'(m.sc)) begin
        errors++;
        $display("FAIL %s: got stall=%b fwd1=%b fwd2=%b cycles=%0d, want stall=%b fwd1=%b fwd2=%b cycles=%0d",
                 m.name, sb.stall, sb.fwd_rs1, sb.fwd_rs2, sb.stall_cycles,
                 m.st, m.f1, m.f2, m.sc);
      end
    end
  end

  task automatic idle();
    reset          = 1'b0;
    sb.dec_valid   = 1'b0;
    sb.dec_rs1     = '0;
    sb.dec_rs2     = '0;
    sb.dec_use_rs1 = 1'b0;
    sb.dec_use_rs2 = 1'b0;
    sb.dec_we      = 1'b0;
    sb.dec_rd      = '0;
    sb.dec_lat     = '0;
    sb.mem_stall   = 1'b0;
    sb.flush       = 1'b0;
    sb.wb_valid    = 1'b0;
    sb.wb_rd       = '0;
  endtask

  task automatic issue(input int rd, input int lat);
    sb.dec_valid = 1'b1;
    sb.dec_we    = 1'b1;
    sb.dec_rd    = RW'(rd);
    sb.dec_lat   = LW'(lat);
  endtask

  task automatic use1(input int r);
    sb.dec_valid   = 1'b1;
    sb.dec_use_rs1 = 1'b1;
    sb.dec_rs1     = RW'(r);
  endtask

  task automatic use2(input int r);
    sb.dec_valid   = 1'b1;
    sb.dec_use_rs2 = 1'b1;
    sb.dec_rs2     = RW'(r);
  endtask

  task automatic wb(input int r);
    sb.wb_valid = 1'b1;
    sb.wb_rd    = RW'(r);
  endtask

  // queue expectation for the cycle just set up, then advance one cycle
  task automatic go(input string nm, input logic st, input logic f1, input logic f2, input int sc);
    exp_t e;
    e.name = nm; e.st = st; e.f1 = f1; e.f2 = f2; e.sc = sc;
    q.push_back(e);
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // reset: outputs forced low even with freeze and a decode request
    reset = 1'b1; sb.mem_stall = 1'b1; use1(5);  go("rst_stall", 0, 0, 0, 0);
    reset = 1'b1;                                 go("rst_idle",  0, 0, 0, 0);

    // load-use, lat=1
    issue(5, 1);        go("lu_issue",   0, 0, 0, 0);
    use1(5);            go("lu_stall",   1, 0, 0, 0);
    use1(5);            go("lu_fwd",     0, 1, 0, 1);
    use1(5); wb(5);     go("lu_wb_same", 0, 1, 0, 1);
    use1(5);            go("lu_after_wb",0, 0, 0, 1);

    // DIV lat=4 consumed via rs2
    issue(7, 4);        go("div_issue",  0, 0, 0, 1);
    use2(7);            go("div_st1",    1, 0, 0, 1);
    use2(7);            go("div_st2",    1, 0, 0, 2);
    use2(7);            go("div_st3",    1, 0, 0, 3);
    use2(7);            go("div_st4",    1, 0, 0, 4);
    use2(7);            go("div_fwd",    0, 0, 1, 5);
    wb(7);              go("div_wb",     0, 0, 0, 5);

    // same, with two mem_stall cycles inside the window -> 6 stalls
    issue(7, 4);                        go("ms_issue", 0, 0, 0, 5);
    use2(7);                            go("ms_st1",   1, 0, 0, 5);
    use2(7); sb.mem_stall = 1'b1;       go("ms_frz1",  1, 0, 0, 6);
    use2(7); sb.mem_stall = 1'b1;       go("ms_frz2",  1, 0, 0, 7);
    use2(7);                            go("ms_st2",   1, 0, 0, 8);
    use2(7);                            go("ms_st3",   1, 0, 0, 9);
    use2(7);                            go("ms_st4",   1, 0, 0, 10);
    use2(7);                            go("ms_fwd",   0, 0, 1, 11);
    wb(7);                              go("ms_wb",    0, 0, 0, 11);

    // register 0 never tracked
    issue(0, 3);                        go("x0_issue", 0, 0, 0, 11);
    for (int i = 0; i < 3; i++) begin
      use1(0); use2(0);                 go("x0_use",   0, 0, 0, 11);
    end

    // WAW: older lat=5, newer lat=0 waits 5 cycles
    issue(9, 5);                        go("waw_mul",  0, 0, 0, 11);
    issue(9, 0);                        go("waw_st1",  1, 0, 0, 11);
    issue(9, 0);                        go("waw_st2",  1, 0, 0, 12);
    issue(9, 0);                        go("waw_st3",  1, 0, 0, 13);
    issue(9, 0);                        go("waw_st4",  1, 0, 0, 14);
    issue(9, 0);                        go("waw_st5",  1, 0, 0, 15);
    issue(9, 0);                        go("waw_go",   0, 0, 0, 16);
    issue(9, 5);                        go("waw_l5a",  0, 0, 0, 16);
    issue(9, 5);                        go("waw_eq",   0, 0, 0, 16);
    issue(9, 4);                        go("waw_lt",   1, 0, 0, 16);
    sb.flush = 1'b1;                    go("waw_flush",0, 0, 0, 17);
    use1(9);                            go("waw_clr",  0, 0, 0, 17);

    // flush squashes in-flight producer and the instruction in decode
    issue(3, 6);                        go("fl_div",   0, 0, 0, 17);
                                        go("fl_gap",   0, 0, 0, 17);
    issue(4, 3); sb.flush = 1'b1;       go("fl_flush", 0, 0, 0, 17);
    use1(3); use2(4);                   go("fl_after", 0, 0, 0, 17);

    // writeback same cycle as a new producer to the same register
    issue(3, 0);                        go("wbi_prod0",0, 0, 0, 17);
    issue(3, 2); wb(3);                 go("wbi_both", 0, 0, 0, 17);
    use1(3);                            go("wbi_st1",  1, 0, 0, 17);
    use1(3);                            go("wbi_st2",  1, 0, 0, 18);
    use1(3);                            go("wbi_fwd",  0, 1, 0, 19);

    // reset mid-operation
    issue(6, 3);                        go("rm_issue", 0, 0, 0, 19);
    reset = 1'b1; use1(6);              go("rm_reset", 0, 0, 0, 19);
    use1(6); use2(3);                   go("rm_after", 0, 0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised, latency-aware scoreboard that replaces the fixed load-use hazard detector between decode and execute. Tracks every architectural register with an outstanding write and a per-register countdown to forwardability, so variable-latency producers (loads, multi-cycle MUL/DIV, cache-miss loads) stall dependent instructions for exactly the required number of cycles. Also asserts bypass selects, enforces WAW ordering, honours a pipeline freeze and a flush, and keeps a saturating stall-cycle counter.

## Interface
- NUM_REGS, 32, architectural registers; register 0 is hard-wired zero and never tracked.
- MAX_LAT, 8, largest producer latency accepted on dec_lat.
- STALL_CNT_W, 32, width of the stall performance counter.
- Derived: RW = $clog2(NUM_REGS); LW = $clog2(MAX_LAT+1).

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- dec_valid  in  1  valid instruction in decode.
- dec_rs1, dec_rs2  in  RW  source registers.
- dec_use_rs1, dec_use_rs2  in  1  instruction actually reads that source.
- dec_we  in  1  instruction writes dec_rd.
- dec_rd  in  RW  destination register.
- dec_lat  in  LW  cycles after issue until result is on the bypass network (0 = forwardable next cycle).
- mem_stall  in  1  pipeline freeze (e.g. cache miss).
- flush  in  1  squash all in-flight producers (branch/exception).
- wb_valid  in  1  register-file write this cycle.
- wb_rd  in  RW  register written.
- stall  out  1  hold decode/fetch, insert bubble.
- fwd_rs1, fwd_rs2  out  1  take source from bypass instead of register file.
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with stall=1.

## Operation
- State per register r≠0: busy[r] (1 bit), cnt[r] (LW bits).
- Issue: issue = dec_valid & ~stall & ~flush. On issue with dec_we=1 and dec_rd≠0: busy[dec_rd]←1, cnt[dec_rd]←dec_lat.
- Countdown: every cycle with mem_stall=0, each busy entry with cnt≠0 decrements by 1 (saturates at 0). mem_stall=1 holds all counts.
- Writeback: wb_valid & wb_rd≠0 clears busy[wb_rd]. Same-cycle issue to the same register wins (entry set to the new producer).
- Flush: clears all busy and cnt on the next edge; has priority over issue and writeback.
- RAW: raw1 = dec_use_rs1 & rs1≠0 & busy[rs1] & cnt[rs1]≠0; raw2 likewise.
- WAW: waw = dec_we & rd≠0 & busy[rd] & cnt[rd] > dec_lat (newer producer must not complete before older).
- stall = dec_valid & (raw1 | raw2 | waw) | mem_stall; forced 0 while reset=1.
- fwd_rsN = dec_use_rsN & rsN≠0 & busy[rsN] & cnt[rsN]==0 (combinational; 0 during reset).
- Register 0: never busy, never stalls, never forwarded, regardless of inputs.
- stall_cycles increments each cycle stall=1, saturates at all-ones.

## Timing
- Reset: all busy=0, cnt=0, stall_cycles=0; stall=0, fwd_rs1=fwd_rs2=0.
- stall and fwd_* are combinational from decode inputs and current state (same-cycle).
- Producer issued in cycle t with lat L: consumer in decode at t+1…t+L stalls (L bubbles, absent mem_stall); at t+L+1 stall=0 and fwd=1 until writeback clears busy.
- Each mem_stall cycle extends the dependence window by one cycle.
- flush asserted in t: cycle t+1 sees no busy entries; the instruction in decode at t does not issue.
- Entry dec_lat > MAX_LAT is illegal (assertion in bench, no RTL behaviour defined).

## Test plan
- Load-use: issue LW x5 lat=1 at t; at t+1 ADD uses x5 -> stall=1 for exactly 1 cycle, at t+2 stall=0, fwd_rs1=1; stall_cycles=1.
- Multi-cycle: DIV x7 lat=4, next instr uses x7 as rs2 -> stall 4 cycles then fwd_rs2=1; with mem_stall pulsed 2 cycles mid-window -> 6 stall cycles total.
- Zero register: producer writes x0 lat=3, consumer reads x0 -> stall=0, fwd=0 all cycles.
- WAW: MUL x9 lat=5 then ADD x9 lat=0 next cycle -> stall until cnt[9]≤0 (5 cycles); with lat=5 second producer -> no stall.
- Flush/writeback: DIV x3 lat=6, flush at t+2 -> consumer of x3 at t+3 stall=0, fwd=0; separately wb_valid x3 same cycle as new issue to x3 lat=2 -> busy[3] stays 1, consumer stalls 2 cycles.
- Reset mid-operation: busy entries with cnt=3, reset for 1 cycle -> stall=0, stall_cycles=0, consumer after reset sees no hazard.
